// File: rtl/seq_counter_pkg.sv
// ============================================================================
// seq_counter_pkg : shared types and helpers for the programmable sequence counter
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_counter_pkg;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_BWD = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;

    // Power-on table contents: entry i holds i modulo 2^width.
    function automatic int unsigned reset_entry(input int unsigned index,
                                                input int unsigned width);
        return index % (32'd1 << width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_table.sv
// ============================================================================
// seq_table : DEPTH x WIDTH register file, async reset to index pattern,
//             synchronous write port, combinational read port
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_table
    import seq_counter_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [IDX_W:0] c_depth = (IDX_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign w_wr_ok = ({1'b0, wr_addr} < c_depth);
    assign w_rd_ok = ({1'b0, rd_addr} < c_depth);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= WIDTH'(reset_entry(i, WIDTH));
            end
        end else if (wr_en && w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Out-of-range addresses only occur for non-power-of-2 depths; read as zero.
    assign rd_data = w_rd_ok ? r_mem[rd_addr] : '0;

endmodule

`default_nettype wire

// File: rtl/seq_counter_prog.sv
// ============================================================================
// seq_counter_prog : programmable sequence counter stepping an index through a
//                    runtime-writable table, with direction, wrap/one-shot mode
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_counter_prog
    import seq_counter_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] count,
    output logic [IDX_W-1:0] idx,
    output logic             wrap,
    output logic             done
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] c_one      = IDX_W'(1);
    localparam logic [IDX_W:0]   c_depth    = (IDX_W + 1)'(DEPTH);

    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_done;

    logic [IDX_W-1:0] w_idx_next;
    logic             w_wrap_next;
    logic             w_done_next;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_tab_data;
    logic             w_load_ok;
    dir_e             w_dir;
    mode_e            w_mode;

    assign w_dir     = dir_e'(dir);
    assign w_mode    = mode_e'(mode);
    assign w_load_ok = ({1'b0, load_idx} < c_depth);

    seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (w_idx_next),
        .rd_data (w_tab_data)
    );

    // Terminal detection compares against the end points explicitly so that
    // non-power-of-2 depths never rely on natural index overflow.
    always_comb begin
        w_idx_next  = r_idx;
        w_wrap_next = 1'b0;
        w_done_next = r_done;
        if (w_mode == MODE_WRAP) begin
            w_done_next = 1'b0;
        end
        if (load) begin
            w_idx_next  = w_load_ok ? load_idx : '0;
            w_done_next = 1'b0;
        end else if (en && !r_done) begin
            if (w_dir == DIR_FWD) begin
                if (r_idx == c_last_idx) begin
                    if (w_mode == MODE_WRAP) begin
                        w_idx_next  = '0;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end else begin
                    w_idx_next = r_idx + c_one;
                end
            end else begin
                if (r_idx == '0) begin
                    if (w_mode == MODE_WRAP) begin
                        w_idx_next  = c_last_idx;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end else begin
                    w_idx_next = r_idx - c_one;
                end
            end
        end
    end

    // Bypass a same-edge write to the entry being entered or held.
    assign w_count_next = (wr_en && (wr_addr == w_idx_next)) ? wr_data : w_tab_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_idx   <= w_idx_next;
            r_count <= w_count_next;
            r_wrap  <= w_wrap_next;
            r_done  <= w_done_next;
        end
    end

    assign count = r_count;
    assign idx   = r_idx;
    assign wrap  = r_wrap;
    assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_counter_prog.sv
// ============================================================================
// tb_seq_counter_prog : self-checking bench for seq_counter_prog, DEPTH=8 and
//                       DEPTH=5 instances against a behavioural table model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_counter_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic       mode;
    logic       load;
    logic [2:0] load_idx;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] wr_data;

    logic [2:0] count_a, idx_a, count_b, idx_b;
    logic       wrap_a, done_a, wrap_b, done_b;

    int nchk;
    int nfail;

    // Model state: instance 0 is DEPTH=8, instance 1 is DEPTH=5
    int dep   [2];
    int m_tab [2][8];
    int m_idx [2];
    int m_cnt [2];
    bit m_wrap[2];
    bit m_done[2];

    seq_counter_prog #(.WIDTH(3), .DEPTH(8)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_idx(load_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count_a), .idx(idx_a), .wrap(wrap_a), .done(done_a)
    );

    seq_counter_prog #(.WIDTH(3), .DEPTH(5)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_idx(load_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count_b), .idx(idx_b), .wrap(wrap_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) m_tab[k][i] = i % 8;
            m_idx[k]  = 0;
            m_cnt[k]  = 0;
            m_wrap[k] = 1'b0;
            m_done[k] = 1'b0;
        end
    endtask

    // One clock edge of the sequence counter, from its behavioural rules
    task automatic model_edge(input int k);
        int d;
        int t;
        int nidx;
        bit nwrap;
        bit ndone;
        d     = dep[k];
        nidx  = m_idx[k];
        nwrap = 1'b0;
        ndone = (mode == 1'b0) ? 1'b0 : m_done[k];
        if (load) begin
            nidx  = (int'(load_idx) < d) ? int'(load_idx) : 0;
            ndone = 1'b0;
        end else if (en && !m_done[k]) begin
            t = m_idx[k] + (dir ? -1 : 1);
            if (t >= 0 && t < d) nidx = t;
            else if (mode == 1'b0) begin
                nidx  = (t + d) % d;
                nwrap = 1'b1;
            end else ndone = 1'b1;
        end
        if (wr_en && int'(wr_addr) < d) m_tab[k][wr_addr] = int'(wr_data);
        m_idx[k]  = nidx;
        m_wrap[k] = nwrap;
        m_done[k] = ndone;
        m_cnt[k]  = m_tab[k][nidx];
    endtask

    task automatic idle_inputs();
        en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_idx = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    // Advance one edge; inputs are driven on negedge, outputs sampled on negedge
    task automatic cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic do_load(input int target);
        load = 1'b1; load_idx = 3'(target);
        cycle();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        nchk++;
        if (idx_a !== 3'd0 || count_a !== 3'd0 || wrap_a !== 1'b0 || done_a !== 1'b0) begin
            nfail++;
            $display("FAIL reset_a idx=%0d count=%0d wrap=%0b done=%0b expected all 0",
                     idx_a, count_a, wrap_a, done_a);
        end
        nchk++;
        if (idx_b !== 3'd0 || count_b !== 3'd0 || wrap_b !== 1'b0 || done_b !== 1'b0) begin
            nfail++;
            $display("FAIL reset_b idx=%0d count=%0d wrap=%0b done=%0b expected all 0",
                     idx_b, count_b, wrap_b, done_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_fwd_wrap();
        en = 1'b1; dir = 1'b0; mode = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cycle();
            nchk++;
            if (count_a !== 3'((k + 1) % 8) || wrap_a !== (k == 7)) begin
                nfail++;
                $display("FAIL fwd_wrap step=%0d count=%0d wrap=%0b expected count=%0d wrap=%0b",
                         k, count_a, wrap_a, (k + 1) % 8, (k == 7));
            end
            nchk++;
            if (idx_b !== 3'(m_idx[1]) || wrap_b !== m_wrap[1]) begin
                nfail++;
                $display("FAIL fwd_wrap_b step=%0d idx=%0d wrap=%0b expected idx=%0d wrap=%0b",
                         k, idx_b, wrap_b, m_idx[1], m_wrap[1]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_table_pattern();
        int pat [8] = '{2, 1, 2, 3, 2, 4, 2, 5};
        for (int a = 0; a < 8; a++) begin
            wr_en = 1'b1; wr_addr = 3'(a); wr_data = 3'(pat[a]);
            cycle();
            nchk++;
            if (count_a !== 3'(m_cnt[0])) begin
                nfail++;
                $display("FAIL write_bypass addr=%0d count=%0d expected %0d", a, count_a, m_cnt[0]);
            end
        end
        wr_en = 1'b0;
        do_load(0);
        nchk++;
        if (count_a !== 3'd2 || idx_a !== 3'd0) begin
            nfail++;
            $display("FAIL pattern_load count=%0d idx=%0d expected count=2 idx=0", count_a, idx_a);
        end
        en = 1'b1; dir = 1'b0; mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            nchk++;
            if (count_a !== 3'(pat[(k + 1) % 8])) begin
                nfail++;
                $display("FAIL pattern_step step=%0d count=%0d expected %0d",
                         k, count_a, pat[(k + 1) % 8]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_oneshot();
        int exp_idx  [4] = '{1, 0, 0, 0};
        bit exp_done [4] = '{0, 0, 1, 1};
        do_load(2);
        en = 1'b1; dir = 1'b1; mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            nchk++;
            if (idx_a !== 3'(exp_idx[k]) || done_a !== exp_done[k] || wrap_a !== 1'b0) begin
                nfail++;
                $display("FAIL oneshot step=%0d idx=%0d done=%0b wrap=%0b expected idx=%0d done=%0b wrap=0",
                         k, idx_a, done_a, wrap_a, exp_idx[k], exp_done[k]);
            end
        end
        en = 1'b0;
        do_load(4);
        nchk++;
        if (idx_a !== 3'd4 || done_a !== 1'b0) begin
            nfail++;
            $display("FAIL oneshot_reload idx=%0d done=%0b expected idx=4 done=0", idx_a, done_a);
        end
        dir = 1'b0; mode = 1'b0;
    endtask

    task automatic test_load_priority();
        do_load(2);
        load = 1'b1; load_idx = 3'd6; en = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 3'b111;
        cycle();
        idle_inputs();
        nchk++;
        if (idx_a !== 3'd6 || count_a !== 3'd7) begin
            nfail++;
            $display("FAIL load_priority idx=%0d count=%0d expected idx=6 count=7", idx_a, count_a);
        end
        nchk++;
        if (idx_b !== 3'(m_idx[1]) || count_b !== 3'(m_cnt[1])) begin
            nfail++;
            $display("FAIL load_priority_b idx=%0d count=%0d expected idx=%0d count=%0d",
                     idx_b, count_b, m_idx[1], m_cnt[1]);
        end
    endtask

    task automatic test_depth5();
        do_load(4);
        en = 1'b1; dir = 1'b0; mode = 1'b0;
        cycle();
        nchk++;
        if (idx_b !== 3'd0 || wrap_b !== 1'b1) begin
            nfail++;
            $display("FAIL d5_fwd_wrap idx=%0d wrap=%0b expected idx=0 wrap=1", idx_b, wrap_b);
        end
        dir = 1'b1;
        cycle();
        nchk++;
        if (idx_b !== 3'd4 || wrap_b !== 1'b1 || count_b !== 3'(m_cnt[1])) begin
            nfail++;
            $display("FAIL d5_bwd_wrap idx=%0d wrap=%0b count=%0d expected idx=4 wrap=1 count=%0d",
                     idx_b, wrap_b, count_b, m_cnt[1]);
        end
        en = 1'b0; dir = 1'b0;
        do_load(7);
        nchk++;
        if (idx_b !== 3'd0 || wrap_b !== 1'b0) begin
            nfail++;
            $display("FAIL d5_load_oob idx=%0d wrap=%0b expected idx=0 wrap=0", idx_b, wrap_b);
        end
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 3'd5;
        cycle();
        wr_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            do_load(k);
            nchk++;
            if (count_b !== 3'(m_cnt[1])) begin
                nfail++;
                $display("FAIL d5_table idx=%0d count=%0d expected %0d", k, count_b, m_cnt[1]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        do_load(5);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 3'd6;
        cycle();
        wr_en = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        nchk++;
        if (idx_a !== 3'd0 || count_a !== 3'd0 || wrap_a !== 1'b0 || done_a !== 1'b0) begin
            nfail++;
            $display("FAIL midrun_reset idx=%0d count=%0d wrap=%0b done=%0b expected all 0",
                     idx_a, count_a, wrap_a, done_a);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k < 8; k++) begin
            do_load(k);
            nchk++;
            if (count_a !== 3'(k)) begin
                nfail++;
                $display("FAIL midrun_table idx=%0d count=%0d expected %0d", k, count_a, k);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            en       = ($urandom_range(0, 9) < 7);
            dir      = 1'($urandom);
            mode     = ($urandom_range(0, 9) < 4);
            load     = ($urandom_range(0, 15) == 0);
            load_idx = 3'($urandom);
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = 3'($urandom);
            wr_data  = 3'($urandom);
            cycle();
            nchk++;
            if (idx_a !== 3'(m_idx[0]) || count_a !== 3'(m_cnt[0]) ||
                wrap_a !== m_wrap[0] || done_a !== m_done[0]) begin
                nfail++;
                $display("FAIL random_a n=%0d idx=%0d count=%0d wrap=%0b done=%0b expected idx=%0d count=%0d wrap=%0b done=%0b",
                         n, idx_a, count_a, wrap_a, done_a, m_idx[0], m_cnt[0], m_wrap[0], m_done[0]);
            end
            nchk++;
            if (idx_b !== 3'(m_idx[1]) || count_b !== 3'(m_cnt[1]) ||
                wrap_b !== m_wrap[1] || done_b !== m_done[1]) begin
                nfail++;
                $display("FAIL random_b n=%0d idx=%0d count=%0d wrap=%0b done=%0b expected idx=%0d count=%0d wrap=%0b done=%0b",
                         n, idx_b, count_b, wrap_b, done_b, m_idx[1], m_cnt[1], m_wrap[1], m_done[1]);
            end
        end
        idle_inputs();
    endtask

    initial begin
        nchk  = 0;
        nfail = 0;
        dep[0] = 8;
        dep[1] = 5;
        test_reset();
        test_fwd_wrap();
        test_table_pattern();
        test_oneshot();
        test_load_priority();
        test_depth5();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

`default_nettype wire
